// File: rtl/f2h_uart_tx_ctrl_if.sv
// Byte-stream and FPGA-to-HPS AXI3 signal bundle for the UART TX sequencer.
// The master modport is the sequencer; the slave modport is the byte producer plus AXI slave port.
interface f2h_uart_tx_ctrl_if;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;

  logic [7:0]  m_awid;
  logic [31:0] m_awaddr;
  logic [3:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst;
  logic [1:0]  m_awlock;
  logic [3:0]  m_awcache;
  logic [2:0]  m_awprot;
  logic [4:0]  m_awuser;
  logic        m_awvalid;
  logic        m_awready;

  logic [7:0]  m_wid;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wlast;
  logic        m_wvalid;
  logic        m_wready;

  logic [7:0]  m_bid;
  logic [1:0]  m_bresp;
  logic        m_bvalid;
  logic        m_bready;

  logic [7:0]  m_arid;
  logic [31:0] m_araddr;
  logic [3:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic [1:0]  m_arlock;
  logic [3:0]  m_arcache;
  logic [2:0]  m_arprot;
  logic [4:0]  m_aruser;
  logic        m_arvalid;
  logic        m_arready;

  logic [7:0]  m_rid;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic        m_rvalid;
  logic        m_rready;

  modport master (
    input  s_data, s_valid,
    output s_ready,
    output m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock, m_awcache, m_awprot, m_awuser,
    output m_awvalid,
    input  m_awready,
    output m_wid, m_wdata, m_wstrb, m_wlast, m_wvalid,
    input  m_wready,
    input  m_bid, m_bresp, m_bvalid,
    output m_bready,
    output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot, m_aruser,
    output m_arvalid,
    input  m_arready,
    input  m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
    output m_rready
  );

  modport slave (
    output s_data, s_valid,
    input  s_ready,
    input  m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock, m_awcache, m_awprot, m_awuser,
    input  m_awvalid,
    output m_awready,
    input  m_wid, m_wdata, m_wstrb, m_wlast, m_wvalid,
    output m_wready,
    output m_bid, m_bresp, m_bvalid,
    input  m_bready,
    input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot, m_aruser,
    input  m_arvalid,
    output m_arready,
    output m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
    input  m_rready
  );
endinterface

// File: rtl/f2h_uart_tx_ctrl.sv
// Drains a byte stream into HPS UART0 THR over the f2h AXI3 port, polling LSR.THRE for FIFO credit.
// Optional F2H_UART_TX_CRLF_EN: an accepted LF is sent as CR then LF.
module f2h_uart_tx_ctrl #(
  parameter logic [31:0] UART_BASE     = 32'hFFC0_2000,
  parameter logic [11:0] THR_OFS       = 12'h000,
  parameter logic [11:0] LSR_OFS       = 12'h014,
  parameter int unsigned TX_FIFO_DEPTH = 16,
  parameter int unsigned POLL_GAP      = 64,
  parameter logic [7:0]  AXI_ID        = 8'h00
) (
  input  logic                      clk_clk,
  input  logic                      reset,
  f2h_uart_tx_ctrl_if.master        bus,
  output logic                      busy,
  output logic                      err
);

  localparam logic [31:0] THR_ADDR    = UART_BASE + {20'h0, THR_OFS};
  localparam logic [31:0] LSR_ADDR    = UART_BASE + {20'h0, LSR_OFS};
  localparam int unsigned GAP_W       = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);
  localparam logic [7:0]  CREDIT_INIT = 8'(TX_FIFO_DEPTH);
  localparam int unsigned LSR_THRE    = 5;

  typedef enum logic [2:0] {
    ST_IDLE, ST_RD_ADDR, ST_RD_DATA, ST_GAP, ST_WR, ST_WR_RESP
  } state_t;

  state_t           state;
  logic [7:0]       hold;
  logic             hold_full;
  logic             s_ready_q;
  logic [7:0]       credit;
  logic [GAP_W-1:0] gap_cnt;
  logic             arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
`ifdef F2H_UART_TX_CRLF_EN
  logic             lf_pend;
`endif

  logic accept;
  assign accept = bus.s_valid & s_ready_q;

  // Fixed single-beat, 32-bit, byte-lane-0 transfer attributes
  assign bus.m_awid    = AXI_ID;
  assign bus.m_awaddr  = THR_ADDR;
  assign bus.m_awlen   = 4'h0;
  assign bus.m_awsize  = 3'b010;
  assign bus.m_awburst = 2'b01;
  assign bus.m_awlock  = 2'b00;
  assign bus.m_awcache = 4'h0;
  assign bus.m_awprot  = 3'h0;
  assign bus.m_awuser  = 5'h00;
  assign bus.m_wid     = AXI_ID;
  assign bus.m_wdata   = {24'h0, hold};
  assign bus.m_wstrb   = 4'b0001;
  assign bus.m_wlast   = 1'b1;
  assign bus.m_arid    = AXI_ID;
  assign bus.m_araddr  = LSR_ADDR;
  assign bus.m_arlen   = 4'h0;
  assign bus.m_arsize  = 3'b010;
  assign bus.m_arburst = 2'b01;
  assign bus.m_arlock  = 2'b00;
  assign bus.m_arcache = 4'h0;
  assign bus.m_arprot  = 3'h0;
  assign bus.m_aruser  = 5'h00;

  assign bus.s_ready   = s_ready_q;
  assign bus.m_arvalid = arvalid_q;
  assign bus.m_rready  = rready_q;
  assign bus.m_awvalid = awvalid_q;
  assign bus.m_wvalid  = wvalid_q;
  assign bus.m_bready  = bready_q;

  // Every non-idle state implies a held byte, so hold_full alone tracks busy
  assign busy = hold_full;

  logic unused_ok;
  assign unused_ok = ^{bus.m_bid, bus.m_rid, bus.m_rlast, bus.m_rdata[31:6], bus.m_rdata[4:0]};

  always_ff @(posedge clk_clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      hold      <= 8'h00;
      hold_full <= 1'b0;
      s_ready_q <= 1'b0;
      credit    <= 8'h00;
      gap_cnt   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      err       <= 1'b0;
`ifdef F2H_UART_TX_CRLF_EN
      lf_pend   <= 1'b0;
`endif
    end else begin
      if (!hold_full && !s_ready_q) s_ready_q <= 1'b1;

      if (accept) begin
        hold_full <= 1'b1;
        s_ready_q <= 1'b0;
`ifdef F2H_UART_TX_CRLF_EN
        if (bus.s_data == 8'h0A) begin
          hold    <= 8'h0D;
          lf_pend <= 1'b1;
        end else begin
          hold    <= bus.s_data;
        end
`else
        hold <= bus.s_data;
`endif
      end

      case (state)
        ST_IDLE: begin
          if (hold_full) begin
            if (credit != 8'h00) begin
              state     <= ST_WR;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state     <= ST_RD_ADDR;
              arvalid_q <= 1'b1;
            end
          end
        end
        ST_RD_ADDR: begin
          if (bus.m_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (bus.m_rvalid) begin
            rready_q <= 1'b0;
            if (bus.m_rresp != 2'b00) err <= 1'b1;
            if (bus.m_rdata[LSR_THRE]) begin
              credit <= CREDIT_INIT;
              state  <= ST_IDLE;
            end else begin
              gap_cnt <= '0;
              state   <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            arvalid_q <= 1'b1;
            state     <= ST_RD_ADDR;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        ST_WR: begin
          // AW and W complete independently; move on once both have handshaken
          if (bus.m_awready) awvalid_q <= 1'b0;
          if (bus.m_wready)  wvalid_q  <= 1'b0;
          if ((!awvalid_q || bus.m_awready) && (!wvalid_q || bus.m_wready)) begin
            bready_q <= 1'b1;
            state    <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (bus.m_bvalid) begin
            bready_q <= 1'b0;
            if (bus.m_bresp != 2'b00) err <= 1'b1;
            credit <= credit - 8'd1;
            state  <= ST_IDLE;
`ifdef F2H_UART_TX_CRLF_EN
            if (lf_pend) begin
              lf_pend <= 1'b0;
              hold    <= 8'h0A;
            end else begin
              hold_full <= 1'b0;
              s_ready_q <= 1'b1;
            end
`else
            hold_full <= 1'b0;
            s_ready_q <= 1'b1;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/f2h_uart_tx_ctrl.md
Name: f2h_uart_tx_ctrl

Overview:
Sequencer that drains a byte stream from FPGA logic into the HPS UART0 transmitter over the FPGA-to-HPS AXI3 slave port. It polls the UART Line Status Register (LSR) over the read channel until THRE=1, then issues single-beat writes to the Transmit Holding Register (THR) while it holds FIFO credit. It sits between FPGA byte producers and the hps_0_f2h_axi_slave_* port of soc_system and is the only master on that port.

Parameters:
UART_BASE, 32'hFFC02000, HPS UART0 base byte address
THR_OFS, 12'h000, THR offset from UART_BASE
LSR_OFS, 12'h014, LSR offset from UART_BASE
TX_FIFO_DEPTH, 16, credits granted per observed THRE=1 (1..255)
POLL_GAP, 64, idle cycles between consecutive LSR polls when THRE=0 (>=1)
AXI_ID, 8'h00, value driven on awid/wid/arid

Ports:
clk_clk  in  1  clock (same domain as the f2h AXI slave)
reset  in  1  asynchronous active-high reset
s_data  in  8  byte to transmit
s_valid  in  1  byte valid
s_ready  out  1  byte accepted when s_valid&s_ready at a rising edge
m_awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awuser  out  8/32/4/3/2/2/4/3/5  AXI3 write address
m_awvalid  out  1 ; m_awready  in  1
m_wid/wdata/wstrb/wlast  out  8/32/4/1 ; m_wvalid  out  1 ; m_wready  in  1
m_bid  in  8 ; m_bresp  in  2 ; m_bvalid  in  1 ; m_bready  out  1
m_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/aruser  out  8/32/4/3/2/2/4/3/5
m_arvalid  out  1 ; m_arready  in  1
m_rid  in  8 ; m_rdata  in  32 ; m_rresp  in  2 ; m_rlast  in  1 ; m_rvalid  in  1 ; m_rready  out  1
busy  out  1  high whenever state != IDLE or the holding register is full
err  out  1  sticky; set on any non-OKAY bresp/rresp; cleared only by reset

Behaviour:
- Constant AXI fields: len=0, size=3'b010, burst=2'b01, lock=0, cache=0, prot=0, user=0, wlast=1, wstrb=4'b0001, wdata={24'h0,hold}. awaddr=UART_BASE+THR_OFS; araddr=UART_BASE+LSR_OFS.
- Holding register `hold` (8b) plus flag hold_full. s_ready = ~hold_full. Accepting a byte sets hold_full on the next edge. No combinational path from s_valid to s_ready.
- credit counter, 8b, reset 0. Never underflows.
- States: IDLE, RD_ADDR, RD_DATA, GAP, WR, WR_RESP.
- IDLE: if hold_full & credit>0 -> WR. If hold_full & credit==0 -> RD_ADDR. Otherwise stay.
- RD_ADDR: arvalid=1 until arready, then -> RD_DATA. arvalid never drops before the handshake.
- RD_DATA: rready=1. On rvalid: if rresp!=0, set err. If rdata[5]=1, credit<=TX_FIFO_DEPTH -> IDLE; else -> GAP.
- GAP: count POLL_GAP cycles, then -> RD_ADDR.
- WR: awvalid and wvalid both assert on entry. Each drops independently after its own handshake, which may be in the same cycle. When both are done -> WR_RESP.
- WR_RESP: bready=1. On bvalid: if bresp!=0, set err. The byte is consumed regardless: hold_full<=0, credit<=credit-1 -> IDLE. The next byte can be accepted in the same cycle hold_full clears, but never earlier.
- Only one outstanding transaction at any time. m_bid and m_rid are ignored.
- Reset values: all valids/readys 0 (s_ready=1 once reset deasserts), state IDLE, credit 0, hold_full 0, err 0, busy 0. Reset asserted mid-transaction aborts immediately. Reset is only ever asserted together with the bridge reset, so no AXI recovery logic is required.
- THRE=1 with TX_FIFO_DEPTH credits means worst-case FIFO-empty. Credits persist while idle because only this block writes THR.

Optional Feature:
F2H_UART_TX_CRLF_EN. Defined: an accepted byte 8'h0A sets flag lf_pend and loads hold=8'h0D. After the 0x0D write completes, hold becomes 8'h0A and is written next, consuming a second credit. hold_full and s_ready stay held (s_ready low) until the 0x0A completes. Undefined: bytes pass through unmodified and lf_pend does not exist.

Test Plan:
- Reset, send 8'h41, slave returns LSR rdata=32'h60 -> exactly one AR to 0xFFC02014, then one AW to 0xFFC02000 with wdata=32'h41, wstrb=4'b0001; credit 16->15; busy drops.
- LSR returns 32'h00 three times then 32'h20 -> four AR transactions, each pair separated by >=64 idle cycles; W occurs only after the 4th.
- Stream 20 bytes with THRE always 1 -> exactly 2 LSR reads: before byte 1 and before byte 17. THR data order is preserved.
- awready delayed 5 cycles while wready is immediate -> wvalid drops after 1 cycle, awvalid holds 5 cycles, and bready is asserted only after both handshakes.
- bresp=2'b10 on a write -> err=1 and stays set; the byte is consumed and the next byte proceeds normally; reset clears err.
- With F2H_UART_TX_CRLF_EN defined, send 8'h0A -> THR writes 0x0D then 0x0A, and s_ready stays low until the second B response.
